// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register (usr): mode encoding and default width.
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } usr_mode_t;

    localparam int USR_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: 4:1 mode mux feeding an async active-low reset flop.
module usr_bit_cell
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic       shr_in,
    input  logic       shl_in,
    input  logic       par_in,
    output logic       q
);

    usr_mode_t mode;
    logic      d;

    assign mode = usr_mode_t'(sel);

    // Any unresolved select value (X/Z in simulation) falls to default and holds.
    always_comb begin
        d = q;
        case (mode)
            MODE_HOLD: d = q;
            MODE_SHR:  d = shr_in;
            MODE_SHL:  d = shl_in;
            MODE_LOAD: d = par_in;
            default:   d = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/usr.sv
// Universal shift register: hold / shift right / shift left / parallel load, one cell per bit.
// Optional macro USR_SERIAL_OUT_EN adds SOUTR/SOUTL serial outputs.
module usr
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_DEFAULT_WIDTH
) (
    input  logic             SINR,
    input  logic             SINL,
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Din,
    input  logic [1:0]       S,
    output logic [WIDTH-1:0] Dout
`ifdef USR_SERIAL_OUT_EN
    ,
    output logic             SOUTR,
    output logic             SOUTL
`endif
);

    logic [WIDTH-1:0] shr_src;
    logic [WIDTH-1:0] shl_src;

    // SINR enters the MSB on a right shift, SINL the LSB on a left shift.
    assign shr_src = {SINR, Dout[WIDTH-1:1]};
    assign shl_src = {Dout[WIDTH-2:0], SINL};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        usr_bit_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .sel    (S),
            .shr_in (shr_src[i]),
            .shl_in (shl_src[i]),
            .par_in (Din[i]),
            .q      (Dout[i])
        );
    end

`ifdef USR_SERIAL_OUT_EN
    // Dout is all-zero in reset, so both serial outputs are 0 there as well.
    assign SOUTR = Dout[0];
    assign SOUTL = Dout[WIDTH-1];
`endif

endmodule

// File: tb/tb_usr.sv
// Directed + randomized scoreboard bench for usr (WIDTH=4); checks serial outputs when USR_SERIAL_OUT_EN is defined.
module tb_usr;

    localparam int W = 4;

    logic         SINR;
    logic         SINL;
    logic         clk;
    logic         rst;
    logic [W-1:0] Din;
    logic [1:0]   S;
    logic [W-1:0] Dout;
`ifdef USR_SERIAL_OUT_EN
    logic         SOUTR;
    logic         SOUTL;
`endif

    usr #(.WIDTH(W)) dut (
        .SINR (SINR),
        .SINL (SINL),
        .clk  (clk),
        .rst  (rst),
        .Din  (Din),
        .S    (S),
        .Dout (Dout)
`ifdef USR_SERIAL_OUT_EN
        ,
        .SOUTR(SOUTR),
        .SOUTL(SOUTL)
`endif
    );

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] model;

    task automatic pulse();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    task automatic drive(input logic [1:0] s, input logic [W-1:0] din,
                         input logic sinr, input logic sinl);
        S    = s;
        Din  = din;
        SINR = sinr;
        SINL = sinl;
    endtask

    task automatic expect_dout(input logic [W-1:0] e);
        sb.push_back(e);
    endtask

    task automatic check_dout(input string tag);
        logic [W-1:0] e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: scoreboard empty, Dout=%b", tag, Dout);
        end else begin
            e = sb.pop_front();
            vectors++;
            assert (Dout === e) else begin
                miscompares++;
                $error("FAIL %s: Dout=%b expected %b", tag, Dout, e);
            end
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic e);
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: got %b expected %b", tag, obs, e);
        end
    endtask

    // Drive, record the expected result, apply one edge, then sample 1ns after the falling edge.
    task automatic step(input logic [1:0] s, input logic [W-1:0] din,
                        input logic sinr, input logic sinl,
                        input logic [W-1:0] e, input string tag);
        drive(s, din, sinr, sinl);
        expect_dout(e);
        pulse();
        #1;
        check_dout(tag);
    endtask

    initial begin
        logic [1:0]   rs;
        logic [W-1:0] rd;
        logic         rr;
        logic         rl;

        clk = 1'b0;
        rst = 1'b0;
        drive(2'b00, '0, 1'b0, 1'b0);
        #3;
        expect_dout(4'b0000);
        check_dout("reset_initial");

        // Reset with clock stopped: Dout=1010 must clear at once.
        #4 rst = 1'b1;
        step(2'b11, 4'b1010, 1'b0, 1'b0, 4'b1010, "preload_1010");
        rst = 1'b0;
        #1;
        expect_dout(4'b0000);
        check_dout("async_reset_immediate");
`ifdef USR_SERIAL_OUT_EN
        check_bit("soutr_in_reset", SOUTR, 1'b0);
        check_bit("soutl_in_reset", SOUTL, 1'b0);
`endif
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 4'b1111, 1'b1, 1'b1, 4'b0000, "edges_ignored_in_reset");
        end
        rst = 1'b1;
        #2;

        // Load and hold.
        step(2'b11, 4'b0001, 1'b0, 1'b0, 4'b0001, "load_0001");
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 4'b1110, 1'b1, 1'b1, 4'b0001, "hold_0001");
        end

        // Shift right with SINR=1; SINL toggled to show it is ignored.
        step(2'b01, 4'b0000, 1'b1, 1'b0, 4'b1000, "shr_1000");
        step(2'b01, 4'b0000, 1'b1, 1'b1, 4'b1100, "shr_1100");
        step(2'b01, 4'b0000, 1'b1, 1'b0, 4'b1110, "shr_1110");
        step(2'b01, 4'b0000, 1'b1, 1'b1, 4'b1111, "shr_1111");

        // Shift left from zero; SINR=1 must have no effect.
        step(2'b11, 4'b0000, 1'b0, 1'b0, 4'b0000, "load_0000");
        step(2'b10, 4'b1111, 1'b1, 1'b1, 4'b0001, "shl_0001");
        step(2'b10, 4'b1111, 1'b1, 1'b1, 4'b0011, "shl_0011");
        step(2'b10, 4'b1111, 1'b1, 1'b0, 4'b0110, "shl_0110");

        // Load overrides both serial inputs.
        step(2'b11, 4'b1010, 1'b1, 1'b1, 4'b1010, "load_over_shift");

        // Unknown select holds.
        step(2'bxx, 4'b0101, 1'b1, 1'b1, 4'b1010, "x_select_hold");

        // Mid-cycle reset discards a pending shift.
        drive(2'b01, 4'b0000, 1'b1, 1'b0);
        #5 clk = 1'b1;
        #2 rst = 1'b0;
        #1;
        expect_dout(4'b0000);
        check_dout("reset_mid_cycle");
        #2 clk = 1'b0;
        step(2'b01, 4'b0000, 1'b1, 1'b0, 4'b0000, "shift_blocked_in_reset");
        rst = 1'b1;
        #2;
        step(2'b01, 4'b0000, 1'b1, 1'b0, 4'b1000, "first_edge_after_reset");

`ifdef USR_SERIAL_OUT_EN
        step(2'b11, 4'b1001, 1'b0, 1'b0, 4'b1001, "load_1001");
        check_bit("soutr_1001", SOUTR, 1'b1);
        check_bit("soutl_1001", SOUTL, 1'b1);
        step(2'b01, 4'b0000, 1'b0, 1'b1, 4'b0100, "shr_0100");
        check_bit("soutr_0100", SOUTR, 1'b0);
        check_bit("soutl_0100", SOUTL, 1'b0);
`endif

        // Randomized modes against a reference model.
        model = Dout;
        for (int i = 0; i < 40; i++) begin
            rs = 2'($urandom_range(0, 3));
            rd = W'($urandom);
            rr = 1'($urandom);
            rl = 1'($urandom);
            case (rs)
                2'b01:   model = {rr, model[W-1:1]};
                2'b10:   model = {model[W-2:0], rl};
                2'b11:   model = rd;
                default: model = model;
            endcase
            step(rs, rd, rr, rl, model, "random");
`ifdef USR_SERIAL_OUT_EN
            check_bit("random_soutr", SOUTR, model[0]);
            check_bit("random_soutl", SOUTL, model[W-1]);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
